// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional build macro MIXCOL_BYPASS_EN adds skip_mix for a pass-through (final round).
module mix_columns_engine #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inv_mode,
`ifdef MIXCOL_BYPASS_EN
    input  logic              skip_mix,
`endif
    input  logic [32*NB-1:0]  state_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  state_out,
    output logic [1:0]        o_dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid-side data is held stable until then, and ready never depends on valid.

    localparam int CW = $clog2(NB) + 1;

    if ((COLS_PER_CYCLE < 1) || ((NB % COLS_PER_CYCLE) != 0)) begin : g_bad_cfg
        $error("mix_columns_engine: COLS_PER_CYCLE must divide NB");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t              r_fsm;
    fsm_t              w_fsm_nxt;
    logic [CW-1:0]     r_cnt;
    logic              r_inv;
    logic [32*NB-1:0]  r_state;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_last;
    logic              w_skip;
    logic [NB-1:0]     w_sel;
    logic [31:0]       w_mixed [NB];

    // GF(2^8) product by a 4-bit constant, built from an xtime chain (poly 0x11B)
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p2, p4, p8;
        p2 = xt(b);
        p4 = xt(p2);
        p8 = xt(p4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? p2 : 8'h00) ^
               (k[2] ? p4 : 8'h00) ^ (k[3] ? p8 : 8'h00);
    endfunction

    function automatic logic [7:0] row(input logic [7:0] x0, input logic [7:0] x1,
                                       input logic [7:0] x2, input logic [7:0] x3,
                                       input logic inv);
        if (inv)
            return gm(x0, 4'he) ^ gm(x1, 4'hb) ^ gm(x2, 4'hd) ^ gm(x3, 4'h9);
        return gm(x0, 4'h2) ^ gm(x1, 4'h3) ^ x2 ^ x3;
    endfunction

    // Each output row uses the same coefficient row applied to rotated inputs
    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {row(a0, a1, a2, a3, inv), row(a1, a2, a3, a0, inv),
                row(a2, a3, a0, a1, inv), row(a3, a0, a1, a2, inv)};
    endfunction

`ifdef MIXCOL_BYPASS_EN
    assign w_skip = skip_mix;
`else
    assign w_skip = 1'b0;
`endif

    assign w_cnt_nxt = r_cnt + CW'(COLS_PER_CYCLE);
    assign w_last    = (w_cnt_nxt == CW'(NB));

    for (genvar c = 0; c < NB; c++) begin : g_col
        assign w_mixed[c] = mix_col(r_state[32*(NB-c)-1 -: 32], r_inv);
        assign w_sel[c]   = (CW'(c) >= r_cnt) && (CW'(c) < w_cnt_nxt);
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: if (in_valid) w_fsm_nxt = w_skip ? S_DONE : S_BUSY;
            S_BUSY: if (w_last) w_fsm_nxt = S_DONE;
            S_DONE: if (out_ready) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
        end else if ((r_fsm == S_IDLE) && in_valid) begin
            r_state <= state_in;
            r_inv   <= inv_mode;
            r_cnt   <= '0;
        end else if (r_fsm == S_BUSY) begin
            for (int c = 0; c < NB; c++) begin
                if (w_sel[c]) r_state[32*(NB-c)-1 -: 32] <= w_mixed[c];
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    assign in_ready    = (r_fsm == S_IDLE);
    assign out_valid   = (r_fsm == S_DONE);
    assign state_out   = r_state;
    assign o_dbg_state = r_fsm;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (COLS_PER_CYCLE 1, 2, 4) against a
// matrix-over-GF(2^8) reference model built from long-division polynomial reduction.
module tb_mix_columns_engine;
  localparam int NB = 4;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic         inv_in    [NI];
  logic [127:0] st_in     [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] st_out    [NI];
  logic [1:0]   dbg       [NI];
`ifdef MIXCOL_BYPASS_EN
  logic         skip      [NI];
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mix_columns_engine #(.NB(NB), .COLS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .inv_mode   (inv_in[g]),
`ifdef MIXCOL_BYPASS_EN
      .skip_mix   (skip[g]),
`endif
      .state_in   (st_in[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .state_out  (st_out[g]),
      .o_dbg_state(dbg[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    logic [31:0]  col;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127 - 32*c -: 32];
      for (int k = 0; k < 4; k++) a[k] = col[31 - 8*k -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = '0;
        for (int k = 0; k < 4; k++) b = b ^ gf_mul(coef[(k - rr + 4) % 4], a[k]);
        r[127 - 32*c - 8*rr -: 8] = b;
      end
    end
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the instance idle; returns at the negedge after handoff.
  task automatic txn(input int k, input logic [127:0] st, input logic inv,
                     output logic [127:0] res, output int lat);
    in_valid[k] = 1'b1;
    st_in[k]    = st;
    inv_in[k]   = inv;
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    inv_in[k]   = $urandom_range(0, 1);
    lat = 0;
    while (!out_valid[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = st_out[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t1_in, t1_exp, res, res2, orig, snap;
    int           lat;

    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; inv_in[k] = 1'b0; st_in[k] = '0; out_ready[k] = 1'b0;
`ifdef MIXCOL_BYPASS_EN
      skip[k] = 1'b0;
`endif
    end
    t1_in  = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    t1_exp = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};

    // reset
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rst_in_ready%0d", k), 128'(in_ready[k]), 128'd1);
      check_eq($sformatf("rst_out_valid%0d", k), 128'(out_valid[k]), 128'd0);
      check_eq($sformatf("rst_state_out%0d", k), st_out[k], 128'd0);
      check_eq($sformatf("rst_dbg%0d", k), 128'(dbg[k]), 128'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // T1 / T2: known vectors and latency on every instance
    for (int k = 0; k < NI; k++) begin
      txn(k, t1_in, 1'b0, res, lat);
      check_eq($sformatf("t1_fwd%0d", k), res, t1_exp);
      check_eq($sformatf("t1_lat%0d", k), 128'(lat), 128'(NB >> k));
      check_eq($sformatf("t1_idle%0d", k), 128'(in_ready[k]), 128'd1);
      txn(k, t1_exp, 1'b1, res, lat);
      check_eq($sformatf("t2_inv%0d", k), res, t1_in);
      check_eq($sformatf("t2_lat%0d", k), 128'(lat), 128'(NB >> k));
    end

    // T3: random round trips
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 200; i++) begin
        orig = rnd128();
        txn(k, orig, 1'b0, res, lat);
        check_eq($sformatf("t3_fwd%0d_%0d", k, i), res, model_mix(orig, 1'b0));
        txn(k, res, 1'b1, res2, lat);
        check_eq($sformatf("t3_rt%0d_%0d", k, i), res2, orig);
        if (i % 16 == 0) check_eq($sformatf("t3_lat%0d_%0d", k, i), 128'(lat), 128'(NB >> k));
      end
    end

    // T4: backpressure in DONE on instance 0
    orig = rnd128();
    in_valid[0] = 1'b1; st_in[0] = orig; inv_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    snap = st_out[0];
    check_eq("t4_result", snap, model_mix(orig, 1'b1));
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = c[0];
      st_in[0]    = rnd128();
      inv_in[0]   = $urandom_range(0, 1);
      @(negedge clk);
      check_eq($sformatf("t4_stable%0d", c), st_out[0], snap);
      check_eq($sformatf("t4_in_ready%0d", c), 128'(in_ready[0]), 128'd0);
      check_eq($sformatf("t4_out_valid%0d", c), 128'(out_valid[0]), 128'd1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check_eq("t4_handoff_ov", 128'(out_valid[0]), 128'd0);
    check_eq("t4_handoff_ir", 128'(in_ready[0]), 128'd1);
    repeat (3) @(negedge clk);
    check_eq("t4_no_ghost", 128'(out_valid[0]), 128'd0);

    // T5: reset during BUSY cycle 2
    in_valid[0] = 1'b1; st_in[0] = rnd128(); inv_in[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("t5_busy", 128'(in_ready[0]), 128'd0);
    rst = 1'b1;
    #1;
    check_eq("t5_async_ov", 128'(out_valid[0]), 128'd0);
    check_eq("t5_async_so", st_out[0], 128'd0);
    @(posedge clk);
    #1;
    check_eq("t5_ov", 128'(out_valid[0]), 128'd0);
    check_eq("t5_ir", 128'(in_ready[0]), 128'd1);
    check_eq("t5_so", st_out[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    orig = rnd128();
    txn(0, orig, 1'b0, res, lat);
    check_eq("t5_after", res, model_mix(orig, 1'b0));
    check_eq("t5_after_lat", 128'(lat), 128'(NB));

`ifdef MIXCOL_BYPASS_EN
    // T6: bypass path
    for (int k = 0; k < NI; k++) begin
      skip[k] = 1'b1;
      txn(k, 128'h00112233445566778899aabbccddeeff, $urandom_range(0, 1), res, lat);
      check_eq($sformatf("t6_skip%0d", k), res, 128'h00112233445566778899aabbccddeeff);
      check_eq($sformatf("t6_skip_lat%0d", k), 128'(lat), 128'd0);
      skip[k] = 1'b0;
      txn(k, t1_in, 1'b0, res, lat);
      check_eq($sformatf("t6_noskip%0d", k), res, t1_exp);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
